// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : game_sequencer
//  Purpose  : Game-flow controller for the road-crossing game. Turns the
//             collision (HIT) and goal (GOAL) pulses from the player datapath
//             into the session flow IDLE -> PLAY -> RESPAWN / LEVEL_UP ->
//             GAME_OVER. Owns lives, level and the two-digit BCD score, and
//             drives the car step period, player enable and the status LED.
//  Ports    : CLK          system clock
//             RST_N        asynchronous active-low reset
//             START        start button level (edge detected here)
//             HIT, GOAL    one-cycle event pulses from the player datapath
//             player_en    player movement enable
//             respawn      one-cycle "return player to spawn" pulse
//             car_period   car step period in CLK cycles
//             level        current level (saturates at MAX_LEVEL)
//             lives        remaining lives
//             score_tens   BCD tens digit
//             score_units  BCD units digit
//             game_over    high while in GAME_OVER
//             LED1         status LED (blinks in LEVEL_UP, on in GAME_OVER)
//             timer_secs   round timer seconds (only with GAME_SEQ_TIMER_EN)
//  Options  : `define GAME_SEQ_TIMER_EN adds a per-round countdown timer whose
//             expiry is handled exactly like a HIT.
//  Revision : 1.0 - initial release
// ============================================================================
module game_sequencer #(
  parameter int LIVES_INIT      = 3,
  parameter int GOALS_PER_LEVEL = 5,
  parameter int MAX_LEVEL       = 7,
  parameter int CAR_PERIOD_BASE = 400000,
  parameter int CAR_PERIOD_STEP = 40000,
  parameter int FREEZE_CYCLES   = 25000000,
  parameter int BLINK_CYCLES    = 6250000
`ifdef GAME_SEQ_TIMER_EN
  ,
  parameter int TIMER_SECONDS   = 30,
  parameter int TICK_CYCLES     = 25000000
`endif
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        HIT,
  input  logic        GOAL,
  output logic        player_en,
  output logic        respawn,
  output logic [31:0] car_period,
  output logic [2:0]  level,
  output logic [1:0]  lives,
  output logic [3:0]  score_tens,
  output logic [3:0]  score_units,
  output logic        game_over,
  output logic        LED1
`ifdef GAME_SEQ_TIMER_EN
  ,
  output logic [7:0]  timer_secs
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_RESPAWN   = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic        player_en_nx, respawn_nx, game_over_nx, led_nx;
  logic [31:0] car_period_nx;
  logic [2:0]  level_nx;
  logic [1:0]  lives_nx;
  logic [3:0]  tens_nx, units_nx;
  logic [3:0]  goal_cnt, goal_cnt_nx;
  logic [31:0] freeze_cnt, freeze_cnt_nx;
  logic [31:0] blink_cnt, blink_cnt_nx;
  logic        start_q, start_armed;
  logic        start_rise;
  logic        hit_evt;
  logic        respawn_req;

  // start_armed only becomes set once START has been seen low after reset,
  // so a button held through reset release cannot launch a game.
  assign start_rise = START & ~start_q & start_armed;

`ifdef GAME_SEQ_TIMER_EN
  logic [7:0]  timer, timer_nx;
  logic [31:0] tick_cnt, tick_cnt_nx;
  assign hit_evt    = HIT | ((state == S_PLAY) && (timer == 8'd0));
  assign timer_secs = timer;
`else
  assign hit_evt = HIT;
`endif

  always_comb begin
    state_nx      = state;
    level_nx      = level;
    lives_nx      = lives;
    tens_nx       = score_tens;
    units_nx      = score_units;
    goal_cnt_nx   = goal_cnt;
    freeze_cnt_nx = freeze_cnt;
    blink_cnt_nx  = blink_cnt;
    led_nx        = LED1;
    respawn_req   = 1'b0;

    case (state)
      S_IDLE, S_GAME_OVER: begin
        if (start_rise) begin
          state_nx    = S_PLAY;
          lives_nx    = 2'(LIVES_INIT);
          level_nx    = 3'd0;
          tens_nx     = 4'd0;
          units_nx    = 4'd0;
          goal_cnt_nx = 4'd0;
          led_nx      = 1'b0;
          respawn_req = 1'b1;
        end
      end
      S_PLAY: begin
        // HIT wins; a GOAL in the same cycle is dropped.
        if (hit_evt) begin
          if (lives > 2'd1) begin
            lives_nx      = lives - 2'd1;
            respawn_req   = 1'b1;
            freeze_cnt_nx = 32'd0;
            state_nx      = S_RESPAWN;
          end else begin
            lives_nx = 2'd0;
            led_nx   = 1'b1;
            state_nx = S_GAME_OVER;
          end
        end else if (GOAL) begin
          respawn_req = 1'b1;
          if (score_tens == 4'd9 && score_units == 4'd9) begin
            tens_nx = score_tens;
          end else if (score_units == 4'd9) begin
            units_nx = 4'd0;
            tens_nx  = score_tens + 4'd1;
          end else begin
            units_nx = score_units + 4'd1;
          end
          if ((goal_cnt + 4'd1) == 4'(GOALS_PER_LEVEL)) begin
            goal_cnt_nx = 4'd0;
            if (int'(level) < MAX_LEVEL) begin
              level_nx      = level + 3'd1;
              freeze_cnt_nx = 32'd0;
              blink_cnt_nx  = 32'd0;
              state_nx      = S_LEVEL_UP;
            end
          end else begin
            goal_cnt_nx = goal_cnt + 4'd1;
          end
        end
      end
      S_RESPAWN: begin
        if (freeze_cnt == 32'(FREEZE_CYCLES - 1)) begin
          freeze_cnt_nx = 32'd0;
          state_nx      = S_PLAY;
        end else begin
          freeze_cnt_nx = freeze_cnt + 32'd1;
        end
      end
      S_LEVEL_UP: begin
        if (freeze_cnt == 32'(FREEZE_CYCLES - 1)) begin
          freeze_cnt_nx = 32'd0;
          blink_cnt_nx  = 32'd0;
          led_nx        = 1'b0;
          state_nx      = S_PLAY;
        end else begin
          freeze_cnt_nx = freeze_cnt + 32'd1;
          if (blink_cnt == 32'(BLINK_CYCLES - 1)) begin
            blink_cnt_nx = 32'd0;
            led_nx       = ~LED1;
          end else begin
            blink_cnt_nx = blink_cnt + 32'd1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // A request arriving while the pulse is still high is merged into it,
    // which keeps respawn from ever lasting two cycles.
    respawn_nx    = respawn_req & ~respawn;
    player_en_nx  = (state_nx == S_PLAY);
    game_over_nx  = (state_nx == S_GAME_OVER);
    // Follows the registered level, so it trails a level change by a cycle.
    car_period_nx = 32'(CAR_PERIOD_BASE) - 32'(level) * 32'(CAR_PERIOD_STEP);

`ifdef GAME_SEQ_TIMER_EN
    timer_nx    = timer;
    tick_cnt_nx = tick_cnt;
    if (respawn_req) begin
      timer_nx    = 8'(TIMER_SECONDS);
      tick_cnt_nx = 32'd0;
    end else if (state == S_PLAY && timer != 8'd0) begin
      if (tick_cnt == 32'(TICK_CYCLES - 1)) begin
        tick_cnt_nx = 32'd0;
        timer_nx    = timer - 8'd1;
      end else begin
        tick_cnt_nx = tick_cnt + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      player_en   <= 1'b0;
      respawn     <= 1'b0;
      level       <= 3'd0;
      lives       <= 2'(LIVES_INIT);
      score_tens  <= 4'd0;
      score_units <= 4'd0;
      goal_cnt    <= 4'd0;
      car_period  <= 32'(CAR_PERIOD_BASE);
      game_over   <= 1'b0;
      LED1        <= 1'b0;
      freeze_cnt  <= 32'd0;
      blink_cnt   <= 32'd0;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
`ifdef GAME_SEQ_TIMER_EN
      timer       <= 8'(TIMER_SECONDS);
      tick_cnt    <= 32'd0;
`endif
    end else begin
      state       <= state_nx;
      player_en   <= player_en_nx;
      respawn     <= respawn_nx;
      level       <= level_nx;
      lives       <= lives_nx;
      score_tens  <= tens_nx;
      score_units <= units_nx;
      goal_cnt    <= goal_cnt_nx;
      car_period  <= car_period_nx;
      game_over   <= game_over_nx;
      LED1        <= led_nx;
      freeze_cnt  <= freeze_cnt_nx;
      blink_cnt   <= blink_cnt_nx;
      start_q     <= START;
      start_armed <= start_armed | ~START;
`ifdef GAME_SEQ_TIMER_EN
      timer       <= timer_nx;
      tick_cnt    <= tick_cnt_nx;
`endif
    end
  end

endmodule
`default_nettype wire
